// File: rtl/pkg_ring.sv
// Shared package for the ring FIFO: default payload width/depth and the
// default-width payload type.
package pkg_ring;

  localparam int DATA_W    = 10;
  localparam int DEPTH_DEF = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/pkg_ring_mem.sv
// Storage array for the ring FIFO: one registered write port and one
// combinational read port.
module pkg_ring_mem #(
  parameter  int WIDTH  = 10,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Contents are deliberately not reset; the FIFO gates reads via its flags.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pkg_ring_fifo.sv
// Single-clock valid/ready ring-buffer FIFO with wrap-bit pointers.
// Optional occupancy outputs (level, almost_full) under PKG_RING_FIFO_LEVEL_EN.
module pkg_ring_fifo import pkg_ring::*; #(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef PKG_RING_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("pkg_ring_fifo: WIDTH must be >= 1 and DEPTH a power of two >= 2");
  end

  ptr_t wr_ptr_reg, wr_ptr_next;
  ptr_t rd_ptr_reg, rd_ptr_next;
  logic overflow_reg, overflow_next;
  logic push, pop;
  logic [WIDTH-1:0] rdata;

  // Same low bits with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                 (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign overflow  = overflow_reg;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg | (in_valid & full);
    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  pkg_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_reg[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign out_data = empty ? '0 : rdata;

`ifdef PKG_RING_FIFO_LEVEL_EN
  localparam ptr_t AF_LEVEL = ptr_t'(DEPTH - 1);

  ptr_t level_reg, level_next;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + PTR_ONE;
      2'b01:   level_next = level_reg - PTR_ONE;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level       = level_reg;
  assign almost_full = (level_reg >= AF_LEVEL);

  // The counter is redundant with the pointer distance; they must never drift.
  a_level_tracks_ptrs : assert property (
    @(posedge clk) disable iff (!rst_n) level_reg == ptr_t'(wr_ptr_reg - rd_ptr_reg)
  );
`endif

endmodule

// File: tb/tb_pkg_ring_fifo.sv
// Directed self-checking bench for pkg_ring_fifo: default 10x8 instance plus a
// 1x2 instance; level/almost_full checks compiled in with PKG_RING_FIFO_LEVEL_EN.
module tb_pkg_ring_fifo;
  import pkg_ring::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic  a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  data_t a_in_data, a_out_data;
  logic  a_full, a_empty, a_overflow;
`ifdef PKG_RING_FIFO_LEVEL_EN
  logic [3:0] a_level;
  logic       a_almost_full;
`endif

  // DEPTH=2, WIDTH=1 instance
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0] b_in_data, b_out_data;
  logic b_full, b_empty, b_overflow;
`ifdef PKG_RING_FIFO_LEVEL_EN
  logic [1:0] b_level;
  logic       b_almost_full;
`endif

  pkg_ring_fifo u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .full      (a_full),
    .empty     (a_empty),
    .overflow  (a_overflow)
`ifdef PKG_RING_FIFO_LEVEL_EN
    ,
    .level       (a_level),
    .almost_full (a_almost_full)
`endif
  );

  pkg_ring_fifo #(.WIDTH(1), .DEPTH(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .full      (b_full),
    .empty     (b_empty),
    .overflow  (b_overflow)
`ifdef PKG_RING_FIFO_LEVEL_EN
    ,
    .level       (b_level),
    .almost_full (b_almost_full)
`endif
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge; outputs are state-only, so sampling 1 ns later is safe.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input data_t d);
    a_in_valid = 1'b1;
    a_in_data  = d;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic a_check_idle(input string tag);
    check({tag, ".empty"},     32'(a_empty),     32'd1);
    check({tag, ".full"},      32'(a_full),      32'd0);
    check({tag, ".in_ready"},  32'(a_in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(a_out_valid), 32'd0);
    check({tag, ".out_data"},  32'(a_out_data),  32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #2;

    // Reset then idle
    do_reset(2);
    tick();
    a_check_idle("rst");
    check("rst.overflow", 32'(a_overflow), 32'd0);
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("rst.level", 32'(a_level), 32'd0);
    check("rst.almost_full", 32'(a_almost_full), 32'd0);
`endif

    // Fill with 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      a_push(data_t'(i));
      check($sformatf("fill%0d.full", i), 32'(a_full), (i == 8) ? 32'd1 : 32'd0);
    end
    check("fill.in_ready", 32'(a_in_ready), 32'd0);
    check("fill.head", 32'(a_out_data), 32'h001);

    // Overflow attempt while full
    a_push(10'h3FF);
    check("ovf.overflow", 32'(a_overflow), 32'd1);
    check("ovf.full", 32'(a_full), 32'd1);
    check("ovf.head", 32'(a_out_data), 32'h001);
    tick();
    check("ovf.sticky", 32'(a_overflow), 32'd1);

    // Drain in order
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d.data", i), 32'(a_out_data), 32'(i));
      tick();
    end
    a_out_ready = 1'b0;
    check("drain.empty", 32'(a_empty), 32'd1);
    check("drain.out_data", 32'(a_out_data), 32'd0);
    check("drain.overflow_held", 32'(a_overflow), 32'd1);

    // Concurrent streaming with 3 entries queued
    do_reset(1);
    check("conc.rst_overflow", 32'(a_overflow), 32'd0);
    for (int i = 0; i < 3; i++) a_push(data_t'(10'h010 + i));
    for (int k = 0; k < 20; k++) begin
      a_in_valid  = 1'b1;
      a_in_data   = data_t'(10'h013 + k);
      a_out_ready = 1'b1;
      check($sformatf("conc%0d.data", k), 32'(a_out_data), 32'h010 + 32'(k));
      tick();
      check($sformatf("conc%0d.flags", k), {30'd0, a_full, a_empty}, 32'd0);
`ifdef PKG_RING_FIFO_LEVEL_EN
      check($sformatf("conc%0d.level", k), 32'(a_level), 32'd3);
`endif
    end
    a_in_valid = 1'b0;
    for (int k = 20; k < 23; k++) begin
      check($sformatf("conc_tail%0d.data", k), 32'(a_out_data), 32'h010 + 32'(k));
      tick();
    end
    a_out_ready = 1'b0;
    check("conc.empty", 32'(a_empty), 32'd1);

    // Full plus simultaneous push/pop: only the pop happens
    do_reset(1);
    for (int i = 0; i < 8; i++) a_push(data_t'(10'h020 + i));
    a_in_valid  = 1'b1;
    a_in_data   = 10'h3FF;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("fullpp.full", 32'(a_full), 32'd0);
    check("fullpp.overflow", 32'(a_overflow), 32'd1);
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("fullpp.level", 32'(a_level), 32'd7);
    check("fullpp.almost_full", 32'(a_almost_full), 32'd1);
`endif
    for (int i = 1; i < 8; i++) begin
      check($sformatf("fullpp_drain%0d", i), 32'(a_out_data), 32'h020 + 32'(i));
      tick();
    end
    a_out_ready = 1'b0;
    check("fullpp.empty", 32'(a_empty), 32'd1);

    // Mid-stream reset with 5 entries
    do_reset(1);
    for (int i = 0; i < 5; i++) a_push(data_t'(10'h030 + i));
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("mid.level", 32'(a_level), 32'd5);
    check("mid.almost_full", 32'(a_almost_full), 32'd0);
`endif
    check("mid.head", 32'(a_out_data), 32'h030);
    rst_n       = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 10'h2AA;
    a_out_ready = 1'b1;
    tick();
    rst_n       = 1'b1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_check_idle("mid_rst");
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("mid_rst.level", 32'(a_level), 32'd0);
`endif
    a_push(10'h155);
    check("mid_push.valid", 32'(a_out_valid), 32'd1);
    check("mid_push.data", 32'(a_out_data), 32'h155);

    // DEPTH=2, WIDTH=1 instance
    check("b_rst.empty", 32'(b_empty), 32'd1);
    check("b_rst.in_ready", 32'(b_in_ready), 32'd1);
    b_in_valid = 1'b1;
    b_in_data  = 1'b1;
    tick();
    check("b_push1.full", 32'(b_full), 32'd0);
    check("b_push1.data", 32'(b_out_data), 32'd1);
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("b_push1.almost_full", 32'(b_almost_full), 32'd1);
`endif
    b_in_data = 1'b0;
    tick();
    check("b_push2.full", 32'(b_full), 32'd1);
`ifdef PKG_RING_FIFO_LEVEL_EN
    check("b_push2.level", 32'(b_level), 32'd2);
`endif
    b_in_data = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check("b_ovf.overflow", 32'(b_overflow), 32'd1);
    check("b_ovf.head", 32'(b_out_data), 32'd1);
    // Stream alternating bits through the 2-entry ring
    b_out_ready = 1'b1;
    check("b_pop1.data", 32'(b_out_data), 32'd1);
    tick();
    check("b_pop2.data", 32'(b_out_data), 32'd0);
    b_in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_in_data = 1'(k % 2 == 0);
      tick();
      check($sformatf("b_conc%0d.data", k), 32'(b_out_data), (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b_conc%0d.valid", k), 32'(b_out_valid), 32'd1);
    end
    b_in_valid = 1'b0;
    tick();
    b_out_ready = 1'b0;
    check("b_end.empty", 32'(b_empty), 32'd1);
    check("b_end.out_data", 32'(b_out_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
